// File: rtl/disp_buf_pingpong.sv
// disp_buf_pingpong: double-buffered display frame store.
// The CPU writes into the back bank through edge-detected PIO control bits.
// The LED tile scanner reads the front bank with one cycle of latency.
// A swap request is executed at the next frame_sync, which keeps frames
// tear-free. A hardware clear fills the back bank with CLR_VAL, one word
// per cycle, while busy is high.
// Optional feature: define DISP_BUF_BYTE_MASK_EN to enable per-byte write
// masking through buf_ctrl[7:4]. Without it, every CPU write is full-word.
module disp_buf_pingpong #(
    parameter int                ADDR_W  = 11,
    parameter int                DATA_W  = 32,
    parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [ADDR_W-1:0] buf_addr,
    input  logic [DATA_W-1:0] buf_data,
    input  logic [7:0]        buf_ctrl,
    input  logic              frame_sync,
    input  logic [ADDR_W-1:0] scan_addr,
    output logic [DATA_W-1:0] scan_data,
    output logic              front_bank,
    output logic              swap_pending,
    output logic              busy,
    output logic              wr_overrun
);

    localparam int              DEPTH     = 1 << ADDR_W;
    localparam int              NUM_BYTES = DATA_W / 8;
    localparam logic [ADDR_W-1:0] CNT_LAST = '1;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [3:0]        ctrl_prev;
    logic              wr_ev, swap_ev, clr_ev, clr_err_ev;
    logic              do_swap;
    logic              wr_drop;
    logic [ADDR_W-1:0] clr_cnt;

    // Shared RAM write port: the clear engine or the CPU.
    logic                  mem_we;
    logic [ADDR_W:0]       mem_waddr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [NUM_BYTES-1:0]  mem_be;

    // Both banks live in one array. The top address bit is the bank index.
    logic [DATA_W-1:0] mem [0:2*DEPTH-1];

    // The mask bits are only partly used, depending on the build and DATA_W.
    logic unused_ctrl;
    assign unused_ctrl = ^buf_ctrl[7:4];

    // Control bits act as events only on their rising edge, so a CPU that
    // holds a bit high produces a single action.
    assign wr_ev      = buf_ctrl[0] & ~ctrl_prev[0];
    assign swap_ev    = buf_ctrl[1] & ~ctrl_prev[1];
    assign clr_ev     = buf_ctrl[2] & ~ctrl_prev[2];
    assign clr_err_ev = buf_ctrl[3] & ~ctrl_prev[3];

    assign busy    = (state_q == S_CLEAR);
    // Swapping is held off while the back bank is being cleared, so a
    // half-cleared bank is never shown.
    assign do_swap = frame_sync & swap_pending & ~busy;
    assign wr_drop = wr_ev & busy;

    // Previous control levels for edge detection.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) ctrl_prev <= '0;
        else                ctrl_prev <= buf_ctrl[3:0];
    end

    // Clear FSM state register.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) state_q <= S_IDLE;
        else                state_q <= state_d;
    end

    // Clear FSM next state. A clear event while busy is ignored.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (clr_ev) state_d = S_CLEAR;
            S_CLEAR: if (clr_cnt == CNT_LAST) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Clear address counter. It wraps back to 0 on the last word.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n)          clr_cnt <= '0;
        else if (state_q == S_CLEAR) clr_cnt <= clr_cnt + 1'b1;
        else                         clr_cnt <= '0;
    end

    // Write-port arbitration. Clear owns the port while busy, so CPU writes
    // in that window are dropped. Both sources target the back bank.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = {~front_bank, buf_addr};
        mem_wdata = buf_data;
        mem_be    = '1;
`ifdef DISP_BUF_BYTE_MASK_EN
        for (int k = 0; k < NUM_BYTES; k++) mem_be[k] = buf_ctrl[4+k];
`endif
        if (state_q == S_CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = {~front_bank, clr_cnt};
            mem_wdata = CLR_VAL;
            mem_be    = '1;
        end else if (wr_ev) begin
            mem_we    = 1'b1;
        end
    end

    // RAM write with byte enables. This block has no reset, so the RAM
    // contents survive reset and the array infers as block RAM.
    always_ff @(posedge clk_clk) begin
        for (int k = 0; k < NUM_BYTES; k++) begin
            if (mem_we && mem_be[k])
                mem[mem_waddr][8*k +: 8] <= mem_wdata[8*k +: 8];
        end
    end

    // Scanner read port with one cycle of latency. On the swap edge this
    // port still samples the old bank.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) scan_data <= '0;
        else                scan_data <= mem[{front_bank, scan_addr}];
    end

    // Bank swap. A request that arrives on the swap edge stays pending.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            front_bank   <= 1'b0;
            swap_pending <= 1'b0;
        end else begin
            if (do_swap) front_bank <= ~front_bank;
            swap_pending <= (swap_pending & ~do_swap) | swap_ev;
        end
    end

    // Sticky overrun flag. A dropped write takes priority over clr_err.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n)  wr_overrun <= 1'b0;
        else if (wr_drop)    wr_overrun <= 1'b1;
        else if (clr_err_ev) wr_overrun <= 1'b0;
    end

endmodule

// File: tb/tb_disp_buf_pingpong.sv
// Scoreboard bench for disp_buf_pingpong (default parameters).
module tb_disp_buf_pingpong;

    localparam int          ADDR_W  = 11;
    localparam int          DATA_W  = 32;
    localparam logic [31:0] CLR_VAL = 32'h0;
    localparam int          DEPTH   = 1 << ADDR_W;

    logic              clk_clk = 1'b0;
    logic              reset_reset_n = 1'b0;
    logic [ADDR_W-1:0] buf_addr = '0;
    logic [DATA_W-1:0] buf_data = '0;
    logic [7:0]        buf_ctrl = '0;
    logic              frame_sync = 1'b0;
    logic [ADDR_W-1:0] scan_addr = '0;
    logic [DATA_W-1:0] scan_data;
    logic              front_bank, swap_pending, busy, wr_overrun;

    int n_vec = 0;
    int n_bad = 0;

    logic [DATA_W-1:0] model [int];
    logic              model_fb = 1'b0;
    logic [DATA_W-1:0] exp_q [$];

    disp_buf_pingpong #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CLR_VAL(CLR_VAL)) dut (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
        .buf_addr(buf_addr), .buf_data(buf_data), .buf_ctrl(buf_ctrl),
        .frame_sync(frame_sync), .scan_addr(scan_addr), .scan_data(scan_data),
        .front_bank(front_bank), .swap_pending(swap_pending),
        .busy(busy), .wr_overrun(wr_overrun)
    );

    always #5 clk_clk = ~clk_clk;

    function automatic int key(input logic b, input logic [ADDR_W-1:0] a);
        return int'({b, a});
    endfunction

    function automatic logic [DATA_W-1:0] model_rd(input logic b, input logic [ADDR_W-1:0] a);
        if (model.exists(key(b, a))) return model[key(b, a)];
        return 'x;
    endfunction

    task automatic model_clear(input logic b);
        for (int a = 0; a < DEPTH; a++) model[key(b, ADDR_W'(a))] = CLR_VAL;
    endtask

    // Full-word write edge to the back bank.
    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        @(negedge clk_clk);
        buf_addr = a; buf_data = d; buf_ctrl = 8'hF1;
        model[key(~model_fb, a)] = d;
        @(negedge clk_clk);
        buf_ctrl = 8'h00;
    endtask

    // Request a swap, then pulse frame_sync.
    task automatic do_swap();
        @(negedge clk_clk); buf_ctrl = 8'h02;
        @(negedge clk_clk); buf_ctrl = 8'h00; frame_sync = 1'b1;
        @(negedge clk_clk); frame_sync = 1'b0;
        model_fb = ~model_fb;
    endtask

    // Pipelined scanner reads; expected words are queued as addresses issue.
    task automatic scan_burst(input logic [ADDR_W-1:0] a0, input int n, input int stride);
        logic [DATA_W-1:0] e;
        for (int i = 0; i <= n; i++) begin
            @(negedge clk_clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if (scan_data !== e) begin
                    n_bad++;
                    $display("FAIL scan_read got %h want %h", scan_data, e);
                end
            end
            if (i < n) begin
                scan_addr = a0 + ADDR_W'(i * stride);
                exp_q.push_back(model_rd(model_fb, scan_addr));
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_clk);
        n_vec += 5;
        if (scan_data !== '0)  begin n_bad++; $display("FAIL rst_scan_data got %h want 0", scan_data); end
        if (front_bank !== 0)  begin n_bad++; $display("FAIL rst_front_bank got %b want 0", front_bank); end
        if (swap_pending !== 0) begin n_bad++; $display("FAIL rst_swap_pending got %b want 0", swap_pending); end
        if (busy !== 0)        begin n_bad++; $display("FAIL rst_busy got %b want 0", busy); end
        if (wr_overrun !== 0)  begin n_bad++; $display("FAIL rst_wr_overrun got %b want 0", wr_overrun); end
        reset_reset_n = 1'b1;
    endtask

    task automatic test_write_swap();
        do_write(11'h005, 32'hDEADBEEF);
        @(negedge clk_clk); buf_ctrl = 8'h02;
        @(negedge clk_clk);
        n_vec += 2;
        if (swap_pending !== 1) begin n_bad++; $display("FAIL ws_pending_set got %b want 1", swap_pending); end
        if (front_bank !== 0)   begin n_bad++; $display("FAIL ws_fb_before got %b want 0", front_bank); end
        buf_ctrl = 8'h00; frame_sync = 1'b1;
        @(negedge clk_clk); frame_sync = 1'b0; model_fb = ~model_fb;
        n_vec += 2;
        if (front_bank !== 1)   begin n_bad++; $display("FAIL ws_fb_after got %b want 1", front_bank); end
        if (swap_pending !== 0) begin n_bad++; $display("FAIL ws_pending_clr got %b want 0", swap_pending); end
        scan_burst(11'h005, 1, 1);
    endtask

    task automatic test_hold_write();
        for (int i = 0; i < 10; i++) do_write(ADDR_W'(11'h020 + i), 32'h1000 + i);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_clk);
            buf_addr = ADDR_W'(11'h020 + i);
            buf_data = 32'h5A5A0000 + i;
            buf_ctrl = 8'hF1;
            if (i == 0) model[key(~model_fb, buf_addr)] = buf_data;
        end
        @(negedge clk_clk); buf_ctrl = 8'h00;
        do_swap();
        scan_burst(11'h020, 10, 1);
    endtask

    task automatic test_clear();
        int cyc, busy_cnt, first;
        cyc = 0; busy_cnt = 0; first = -1;
        @(negedge clk_clk); buf_ctrl = 8'h04;
        while (cyc < 5000) begin
            @(negedge clk_clk); cyc++;
            if (busy) begin
                if (first < 0) first = cyc;
                busy_cnt++;
                if (busy_cnt == 100) begin
                    buf_addr = 11'h7FF; buf_data = 32'h12345678; buf_ctrl = 8'h05;
                end else buf_ctrl = 8'h04;
            end else if (busy_cnt > 0) break;
        end
        buf_ctrl = 8'h00;
        n_vec += 3;
        if (first !== 1)       begin n_bad++; $display("FAIL clr_busy_rise got %0d want 1", first); end
        if (busy_cnt !== 2048) begin n_bad++; $display("FAIL clr_busy_len got %0d want 2048", busy_cnt); end
        if (wr_overrun !== 1)  begin n_bad++; $display("FAIL clr_overrun_set got %b want 1", wr_overrun); end
        model_clear(~model_fb);
        do_swap();
        scan_burst(11'h7FF, 3, 1027);
        @(negedge clk_clk); buf_ctrl = 8'h08;
        @(negedge clk_clk);
        n_vec++;
        if (wr_overrun !== 0) begin n_bad++; $display("FAIL clr_err got %b want 0", wr_overrun); end
        buf_ctrl = 8'h00;
    endtask

    task automatic test_swap_boundary();
        int cyc, busy_cnt, moved;
        @(negedge clk_clk); buf_ctrl = 8'h02; frame_sync = 1'b1;
        @(negedge clk_clk); buf_ctrl = 8'h00; frame_sync = 1'b0;
        n_vec += 2;
        if (front_bank !== model_fb) begin n_bad++; $display("FAIL sb_same_cycle_fb got %b want %b", front_bank, model_fb); end
        if (swap_pending !== 1)      begin n_bad++; $display("FAIL sb_same_cycle_pend got %b want 1", swap_pending); end
        // Write edge coincides with the swap, so it lands in the pre-swap back bank.
        @(negedge clk_clk);
        frame_sync = 1'b1; buf_addr = 11'h030; buf_data = 32'hCAFEF00D; buf_ctrl = 8'hF1;
        model[key(~model_fb, 11'h030)] = 32'hCAFEF00D;
        @(negedge clk_clk); frame_sync = 1'b0; buf_ctrl = 8'h00; model_fb = ~model_fb;
        n_vec += 2;
        if (front_bank !== model_fb) begin n_bad++; $display("FAIL sb_next_fs_fb got %b want %b", front_bank, model_fb); end
        if (swap_pending !== 0)      begin n_bad++; $display("FAIL sb_next_fs_pend got %b want 0", swap_pending); end
        scan_burst(11'h030, 1, 1);
        // The swap must wait for the clear to finish.
        @(negedge clk_clk); buf_ctrl = 8'h02;
        @(negedge clk_clk); buf_ctrl = 8'h04;
        cyc = 0; busy_cnt = 0; moved = 0;
        while (cyc < 5000) begin
            @(negedge clk_clk); cyc++;
            if (front_bank !== model_fb) moved++;
            frame_sync = (cyc % 300 == 5);
            if (busy) busy_cnt++;
            else if (busy_cnt > 0) break;
        end
        frame_sync = 1'b0; buf_ctrl = 8'h00;
        n_vec += 3;
        if (moved !== 0)        begin n_bad++; $display("FAIL sb_defer_fb got %0d swaps want 0", moved); end
        if (swap_pending !== 1) begin n_bad++; $display("FAIL sb_defer_pend got %b want 1", swap_pending); end
        if (busy_cnt !== 2048)  begin n_bad++; $display("FAIL sb_defer_busy got %0d want 2048", busy_cnt); end
        model_clear(~model_fb);
        @(negedge clk_clk); frame_sync = 1'b1;
        @(negedge clk_clk); frame_sync = 1'b0; model_fb = ~model_fb;
        n_vec++;
        if (front_bank !== model_fb) begin n_bad++; $display("FAIL sb_after_busy_fb got %b want %b", front_bank, model_fb); end
        scan_burst(11'h030, 1, 1);
    endtask

`ifdef DISP_BUF_BYTE_MASK_EN
    task automatic test_byte_mask();
        do_write(11'h010, 32'h11223344);
        @(negedge clk_clk); buf_addr = 11'h010; buf_data = 32'hAABBCCDD; buf_ctrl = 8'h51;
        @(negedge clk_clk); buf_ctrl = 8'h00;
        @(negedge clk_clk); buf_data = 32'hFFFFFFFF; buf_ctrl = 8'h01;
        @(negedge clk_clk); buf_ctrl = 8'h00;
        model[key(~model_fb, 11'h010)] = 32'h11BB33DD;
        do_swap();
        scan_burst(11'h010, 1, 1);
        n_vec++;
        if (wr_overrun !== 0) begin n_bad++; $display("FAIL bm_no_overrun got %b want 0", wr_overrun); end
    endtask
`endif

    task automatic test_reset_mid_clear();
        int cyc, busy_cnt;
        do_write(11'h040, 32'h0BADCAFE);
        do_swap();
        if (model_fb == 1'b0) begin
            do_write(11'h040, 32'h0BADCAFE);
            do_swap();
        end
        scan_burst(11'h040, 1, 1);
        @(negedge clk_clk); buf_ctrl = 8'h02;
        @(negedge clk_clk); buf_ctrl = 8'h04;
        cyc = 0; busy_cnt = 0;
        while (cyc < 5000 && busy_cnt < 12'h300) begin
            @(negedge clk_clk); cyc++;
            if (busy) busy_cnt++;
        end
        n_vec += 2;
        if (busy !== 1)         begin n_bad++; $display("FAIL rmc_busy_pre got %b want 1", busy); end
        if (swap_pending !== 1) begin n_bad++; $display("FAIL rmc_pend_pre got %b want 1", swap_pending); end
        #2 reset_reset_n = 1'b0; buf_ctrl = 8'h00;
        #1;
        n_vec += 5;
        if (busy !== 0)         begin n_bad++; $display("FAIL rmc_busy got %b want 0", busy); end
        if (swap_pending !== 0) begin n_bad++; $display("FAIL rmc_pend got %b want 0", swap_pending); end
        if (front_bank !== 0)   begin n_bad++; $display("FAIL rmc_fb got %b want 0", front_bank); end
        if (scan_data !== '0)   begin n_bad++; $display("FAIL rmc_scan_data got %h want 0", scan_data); end
        if (wr_overrun !== 0)   begin n_bad++; $display("FAIL rmc_overrun got %b want 0", wr_overrun); end
        @(negedge clk_clk); reset_reset_n = 1'b1;
        model_fb = 1'b0;
        for (int a = 0; a < DEPTH; a++) model.delete(key(1'b0, ADDR_W'(a)));
        @(negedge clk_clk); buf_ctrl = 8'h04;
        cyc = 0; busy_cnt = 0;
        while (cyc < 5000) begin
            @(negedge clk_clk); cyc++;
            if (busy) busy_cnt++;
            else if (busy_cnt > 0) break;
        end
        buf_ctrl = 8'h00;
        n_vec++;
        if (busy_cnt !== 2048) begin n_bad++; $display("FAIL rmc_reclear_len got %0d want 2048", busy_cnt); end
        model_clear(~model_fb);
        do_swap();
        scan_burst(11'h040, 1, 1);
    endtask

    initial begin
        test_reset();
        test_write_swap();
        test_hold_write();
        test_clear();
        test_swap_boundary();
`ifdef DISP_BUF_BYTE_MASK_EN
        test_byte_mask();
`endif
        test_reset_mid_clear();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/disp_buf_pingpong.md
Name: disp_buf_pingpong

Overview:
- Parametrised successor to the single-bank display-buffer PIO interface.
- Turns the CPU-side display_buffer addr/data/ctrl PIO exports into writes to a double-buffered (ping-pong) frame store.
- Gives the LED tile scanner a 1-cycle-latency read port on the front bank.
- Adds frame-synchronous bank swap, hardware back-bank clear, and an overrun flag.

Parameters:
- ADDR_W, 11: word address width; each bank holds 2^ADDR_W words.
- DATA_W, 32: word width; must be a multiple of 8 and at most 32.
- CLR_VAL, 0: DATA_W-wide value written by the clear operation.

Ports:
- clk_clk  in  1  system clock; all logic on its rising edge.
- reset_reset_n  in  1  asynchronous active-low reset.
- buf_addr  in  ADDR_W  CPU write address (display_buffer_addr export).
- buf_data  in  DATA_W  CPU write data (display_buffer_data export).
- buf_ctrl  in  8  control; [0] wr, [1] swap, [2] clear, [3] clr_err, [7:4] byte mask (optional feature).
- frame_sync  in  1  one-cycle pulse from the scanner at end of frame.
- scan_addr  in  ADDR_W  scanner read address.
- scan_data  out  DATA_W  front-bank word, registered.
- front_bank  out  1  current front bank index.
- swap_pending  out  1  swap requested, not yet done.
- busy  out  1  clear in progress.
- wr_overrun  out  1  sticky: a write was dropped during clear.

Behaviour:
- Reset:
  - All outputs 0. FSM enters IDLE. Edge-detect registers 0. front_bank 0.
  - RAM contents are not reset.
  - Reset mid-clear aborts the clear; back-bank contents are then undefined.
- Control decode:
  - buf_ctrl[3:0] is registered each cycle (prev).
  - An event fires on a rising edge: buf_ctrl[i] & ~prev[i].
  - Inputs are in the clk_clk domain; no synchroniser.
- Write event:
  - Data word is written to back bank (~front_bank) at buf_addr in the same cycle the edge is detected.
  - buf_addr and buf_data are sampled in that cycle.
  - If busy: the write is dropped and wr_overrun is set.
- Swap event: sets swap_pending.
- Swap execution:
  - Occurs on the rising edge where frame_sync & swap_pending & ~busy.
  - front_bank toggles and swap_pending clears.
  - If frame_sync arrives while busy, the swap is deferred to the next frame_sync after busy falls.
- Swap timing boundaries:
  - A swap event in the same cycle as frame_sync sets pending only; the swap happens at the following frame_sync.
  - A write edge in the same cycle as the swap uses the pre-swap back bank.
- Clear event:
  - FSM moves IDLE -> CLEAR. busy rises the next cycle.
  - A counter 0..2^ADDR_W-1 writes CLR_VAL to the back bank, one word per cycle.
  - After the last word, FSM returns to IDLE and busy falls. busy is high for exactly 2^ADDR_W cycles.
  - A clear event while busy is ignored.
- clr_err event: clears wr_overrun. If it coincides with a dropped write, set wins.
- Scan read:
  - scan_data <= RAM[front_bank][scan_addr], latency 1.
  - A read sampled on the swap edge returns old-bank data; the next read returns new-bank data.
- RAM:
  - Simple dual-port: one write port (CPU or clear, arbitrated by FSM), one read port.
  - Inferable as M9K, 2·2^ADDR_W × DATA_W.
  - A read and write to the same location in the same cycle cannot occur, because writes always target the back bank and reads the front bank.

Optional Feature:
- Macro: DISP_BUF_BYTE_MASK_EN.
- Defined:
  - buf_ctrl[4+k] enables byte lane k (bits 8k+7:8k) for k < DATA_W/8.
  - Unmasked lanes keep their old contents (RAM byte-enable).
  - A mask of 0 writes nothing, and does not set overrun unless busy.
  - Clear ignores the mask.
- Undefined: buf_ctrl[7:4] is ignored and every write is full-word.

Test Plan:
- Reset, then write 0xDEADBEEF to addr 0x005 (ctrl 0x00->0x01), raise ctrl[1], pulse frame_sync; scan_addr=0x005 -> scan_data=0xDEADBEEF one cycle later, front_bank=1, swap_pending=0.
- Hold ctrl[0]=1 for 10 cycles with changing addr -> exactly one RAM write, at the edge cycle only.
- Clear edge, ADDR_W=11 -> busy high 2048 cycles. Write edge mid-clear -> wr_overrun=1, word not written. Swap, then scan addr 0x7FF -> CLR_VAL. clr_err edge -> wr_overrun=0.
- swap edge and frame_sync in the same cycle -> front_bank unchanged; next frame_sync -> toggles. frame_sync during busy with pending -> no swap until first frame_sync after busy falls.
- With DISP_BUF_BYTE_MASK_EN: addr 0x010 holds 0x11223344, write 0xAABBCCDD with mask 0b0101 -> 0x11BB33DD after swap.
- Assert reset_reset_n low mid-clear (counter ≈0x300) -> busy, swap_pending, front_bank, scan_data all 0 asynchronously. A new clear after release runs the full 2048 cycles.
